// File: rtl/led_pattern_gen_if.sv
// Mode request handshake between a controller and the LED pattern generator.
// The requester drives mode/mode_valid; the generator answers with mode_ready.
interface led_pattern_gen_if;
   logic [1:0] mode;
   logic       mode_valid;
   logic       mode_ready;

   modport master (output mode, output mode_valid, input mode_ready);
   modport slave  (input mode, input mode_valid, output mode_ready);
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: binary count, bouncing scanner, PWM breathe, off.
// Pattern state steps on a prescaled tick; mode changes are deferred to the next tick.
module led_pattern_gen #(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int STEP_MS     = 125,
   parameter int NLED        = 8,
   parameter int NCH         = 3,
   parameter int PWM_BITS    = 6,
   parameter int USEIOFF     = 1
) (
   input  logic                clk_12mhz,
   input  logic                rst_n,
   led_pattern_gen_if.slave    mode_bus,
   output logic [NCH*NLED-1:0] led_n,
   output logic                step_tick
);

   localparam int STEP_CYCLES = CLK_FREQ_HZ / 1000 * STEP_MS;
   localparam int PRESC_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int POS_W       = $clog2(NLED);
   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);
   localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(NLED - 1);
   localparam logic [POS_W-1:0]    POS_PREV   = POS_W'(NLED - 2);
   localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_OFF     = 2'd3
   } mode_t;

   logic [PRESC_W-1:0]  presc_reg, presc_next;
   logic [PWM_BITS-1:0] pwm_cnt_reg;
   mode_t               mode_reg, mode_next;
   logic                pend_valid_reg, pend_valid_next;
   mode_t               pend_mode_reg, pend_mode_next;
   logic [NLED-1:0]     count_reg, count_next;
   logic [POS_W-1:0]    pos_reg, pos_next;
   logic                dir_up_reg, dir_up_next;
   logic [PWM_BITS-1:0] duty_reg, duty_next;
   logic                duty_up_reg, duty_up_next;
   logic                accept;
   logic [NLED-1:0]     base_pattern;
   logic [NCH*NLED-1:0] led_pattern;

   assign step_tick           = (presc_reg == PRESC_LAST);
   assign mode_bus.mode_ready = ~pend_valid_reg;
   assign accept              = mode_bus.mode_valid & ~pend_valid_reg;

   always_ff @(posedge clk_12mhz or negedge rst_n) begin
      if (!rst_n) begin
         presc_reg      <= '0;
         mode_reg       <= MODE_COUNT;
         pend_valid_reg <= 1'b0;
         pend_mode_reg  <= MODE_COUNT;
         count_reg      <= '0;
         pos_reg        <= '0;
         dir_up_reg     <= 1'b1;
         duty_reg       <= '0;
         duty_up_reg    <= 1'b1;
      end else begin
         presc_reg      <= presc_next;
         mode_reg       <= mode_next;
         pend_valid_reg <= pend_valid_next;
         pend_mode_reg  <= pend_mode_next;
         count_reg      <= count_next;
         pos_reg        <= pos_next;
         dir_up_reg     <= dir_up_next;
         duty_reg       <= duty_next;
         duty_up_reg    <= duty_up_next;
      end
   end

   // PWM counter free-runs regardless of mode so the duty window is always a full period.
   always_ff @(posedge clk_12mhz or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
   end

   always_comb begin
      presc_next      = step_tick ? '0 : presc_reg + 1'b1;
      mode_next       = mode_reg;
      pend_valid_next = pend_valid_reg;
      pend_mode_next  = pend_mode_reg;
      count_next      = count_reg;
      pos_next        = pos_reg;
      dir_up_next     = dir_up_reg;
      duty_next       = duty_reg;
      duty_up_next    = duty_up_reg;

      if (accept) begin
         pend_valid_next = 1'b1;
         pend_mode_next  = mode_t'(mode_bus.mode);
      end

      // A request accepted in a tick cycle only becomes pending after it, so it waits a full step.
      if (step_tick) begin
         if (pend_valid_reg) begin
            mode_next       = pend_mode_reg;
            pend_valid_next = 1'b0;
            count_next      = '0;
            pos_next        = '0;
            dir_up_next     = 1'b1;
            duty_next       = '0;
            duty_up_next    = 1'b1;
         end else begin
            case (mode_reg)
               MODE_COUNT: count_next = count_reg + 1'b1;
               MODE_SCAN: begin
                  if (dir_up_reg) begin
                     if (pos_reg == POS_LAST) begin
                        pos_next    = POS_PREV;
                        dir_up_next = 1'b0;
                     end else begin
                        pos_next = pos_reg + 1'b1;
                     end
                  end else begin
                     if (pos_reg == '0) begin
                        pos_next    = POS_W'(1);
                        dir_up_next = 1'b1;
                     end else begin
                        pos_next = pos_reg - 1'b1;
                     end
                  end
               end
               MODE_BREATHE: begin
                  if (duty_up_reg) begin
                     if (duty_reg == DUTY_MAX) begin
                        duty_next    = DUTY_MAX - 1'b1;
                        duty_up_next = 1'b0;
                     end else begin
                        duty_next = duty_reg + 1'b1;
                     end
                  end else begin
                     if (duty_reg == '0) begin
                        duty_next    = PWM_BITS'(1);
                        duty_up_next = 1'b1;
                     end else begin
                        duty_next = duty_reg - 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      base_pattern = '0;
      case (mode_reg)
         MODE_COUNT:   base_pattern = count_reg;
         MODE_SCAN:    base_pattern = NLED'(1) << pos_reg;
         MODE_BREATHE: base_pattern = (pwm_cnt_reg < duty_reg) ? '1 : '0;
         default:      base_pattern = '0;
      endcase
   end

   // Channel gi shows the base pattern rotated left by gi; breathe/off are rotation-invariant.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      localparam int ROT = gi % NLED;
      for (genvar gj = 0; gj < NLED; gj++) begin : g_bit
         assign led_pattern[gi*NLED + gj] = base_pattern[(gj + NLED - ROT) % NLED];
      end
   end

   if (USEIOFF != 0) begin : g_ioff
      (* syn_useioff = 1, syn_preserve = 1 *) logic [NCH*NLED-1:0] led_n_reg;
      always_ff @(posedge clk_12mhz or negedge rst_n) begin
         if (!rst_n) begin
            led_n_reg <= '1;
         end else begin
            led_n_reg <= ~led_pattern;
         end
      end
      assign led_n = led_n_reg;
   end else begin : g_fabric
      (* syn_useioff = 0, syn_preserve = 1 *) logic [NCH*NLED-1:0] led_n_reg;
      always_ff @(posedge clk_12mhz or negedge rst_n) begin
         if (!rst_n) begin
            led_n_reg <= '1;
         end else begin
            led_n_reg <= ~led_pattern;
         end
      end
      assign led_n = led_n_reg;
   end

endmodule
